pixel_mode_pipeline: RTL



---
 rtl/pixel_mode_pipeline.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pixel_mode_pipeline.sv
// Two-stage pixel stream processor: per-frame mode/level latched at sop, per-pixel transform, frame tracking.
// Optional build macro PIXEL_MODE_LEN_EN adds last_frame_len reporting.
module pixel_mode_pipeline #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 4,
    parameter int LVL_W  = 2,
    parameter int FCNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*CH_W-1:0]   in_data,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               mode_req,
    input  logic [LVL_W-1:0]         level_req,
    output logic [NUM_CH*CH_W-1:0]   out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               active_mode,
    output logic [LVL_W-1:0]         active_level,
    output logic [FCNT_W-1:0]        frame_count,
    output logic                     sop_err
`ifdef PIXEL_MODE_LEN_EN
    ,output logic [15:0]             last_frame_len
`endif
);
    localparam int DATA_W = NUM_CH * CH_W;
    localparam logic [CH_W-1:0] MAX = '1;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    // Valid/ready: a beat moves on a clock edge where both valid and ready are high;
    // a stalled output (valid && !ready) keeps data/sop/eop stable until taken.
    logic              s1_valid, s1_sop, s1_eop;
    logic [DATA_W-1:0] s1_data;
    logic              s2_valid, s2_sop, s2_eop;
    logic [DATA_W-1:0] s2_data;
    logic              s1_adv, s1_load, accept;

    assign s1_adv   = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s1_adv;
    assign in_ready = !reset && s1_load;
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_sop   = s2_sop;
    assign out_eop   = s2_eop;

    // The sop beat must already use the requested settings, so bypass the latch on sop.
    logic [1:0]        eff_mode;
    logic [LVL_W-1:0]  eff_level;
    logic [CH_W-1:0]   thr, ch_max, ch_x;
    logic [DATA_W-1:0] xf_data;

    assign eff_mode  = in_sop ? mode_req  : active_mode;
    assign eff_level = in_sop ? level_req : active_level;

    always_comb begin
        thr     = CH_W'(eff_level);
        thr     = thr << (CH_W - LVL_W);
        ch_max  = '0;
        ch_x    = '0;
        xf_data = in_data;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_data[k*CH_W +: CH_W] > ch_max) ch_max = in_data[k*CH_W +: CH_W];
        end
        for (int k = 0; k < NUM_CH; k++) begin
            ch_x = in_data[k*CH_W +: CH_W];
            case (eff_mode)
                2'd0:    xf_data[k*CH_W +: CH_W] = ch_x;
                2'd1:    xf_data[k*CH_W +: CH_W] = MAX - ch_x;
                2'd2:    xf_data[k*CH_W +: CH_W] = ch_max;
                default: xf_data[k*CH_W +: CH_W] = (ch_x >= thr) ? MAX : '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_sop       <= 1'b0;
            s1_eop       <= 1'b0;
            s1_data      <= '0;
            s2_valid     <= 1'b0;
            s2_sop       <= 1'b0;
            s2_eop       <= 1'b0;
            s2_data      <= '0;
            active_mode  <= '0;
            active_level <= '0;
        end else begin
            if (s1_adv) begin
                s2_valid <= s1_valid;
                s2_sop   <= s1_sop;
                s2_eop   <= s1_eop;
                s2_data  <= s1_data;
            end
            if (s1_load) begin
                s1_valid <= in_valid;
                s1_sop   <= in_sop;
                s1_eop   <= in_eop;
                s1_data  <= xf_data;
            end
            if (accept && in_sop) begin
                active_mode  <= mode_req;
                active_level <= level_req;
            end
        end
    end

    // Framing FSM: sop/eop on one beat is a complete 1-beat frame.
    state_t state_q, state_d;
    logic   count_en, err_d;

    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        err_d    = 1'b0;
        if (accept) begin
            if (in_sop) begin
                err_d = (state_q == IN_FRAME);
                if (in_eop) begin
                    state_d  = IDLE;
                    count_en = 1'b1;
                end else begin
                    state_d = IN_FRAME;
                end
            end else if (in_eop && state_q == IN_FRAME) begin
                state_d  = IDLE;
                count_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sop_err     <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q <= state_d;
            sop_err <= err_d;
            if (count_en) frame_count <= frame_count + FCNT_W'(1);
        end
    end

`ifdef PIXEL_MODE_LEN_EN
    logic [15:0] len_cnt, len_nxt;

    assign len_nxt = (len_cnt == 16'hFFFF) ? len_cnt : len_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            len_cnt        <= '0;
            last_frame_len <= '0;
        end else if (accept) begin
            if (in_sop) begin
                len_cnt <= 16'd1;
                if (in_eop) last_frame_len <= 16'd1;
            end else if (state_q == IN_FRAME) begin
                len_cnt <= len_nxt;
                if (in_eop) last_frame_len <= len_nxt;
            end
        end
    end
`endif

endmodule
